// File: rtl/run_sequencer.sv
// run_sequencer: start/ack run control in front of the 9-bit core (IDLE/ARMED/RUN/FINISH).
// Latency: outputs are flop decodes and change one clk edge after the input that causes them.
// Backpressure: none. The start/ack level handshake paces runs. Watchdog built only with RUN_SEQUENCER_WATCHDOG_EN.
module run_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  output logic             run_en,
  output logic             pc_clear,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Catch a watchdog limit the counter cannot represent, or a zero limit.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > ((2 ** CNT_W) - 1))) begin : g_bad_timeout
    $error("run_sequencer: TIMEOUT_CYCLES out of range for CNT_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             wd_hit;

  // Saturating increment: a runaway program pins the count at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(TIMEOUT_CYCLES);
  logic [CNT_W:0] cnt_plus1;

  // The watchdog fires on the RUN cycle that would complete TIMEOUT_CYCLES cycles.
  // The extra bit keeps the +1 compare exact when the count is at all-ones.
  assign cnt_plus1 = {1'b0, cnt_q} + 1'b1;
  assign wd_hit    = (cnt_plus1 == TIMEOUT_V);
`else
  assign wd_hit    = 1'b0;
`endif

  // Next-state, counter and timeout-flag logic. Every entry into ARMED starts a clean run record.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ARMED;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ARMED: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (!start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The cycle that decodes the halt still counts as a RUN cycle.
        cnt_d = cnt_inc;
        if (done) begin
          state_d   = FINISH;
          timeout_d = 1'b0;
        end else if (wd_hit) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end
      end
      FINISH: begin
        // Count and timeout stay frozen for the testbench until the next start.
        if (start) begin
          state_d   = ARMED;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // State, counter and timeout registers. Reset is asynchronous, so outputs clear mid-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode flops only. No input reaches an output in the same cycle.
  assign run_en      = (state_q == RUN);
  assign pc_clear    = (state_q == ARMED);
  assign ack         = (state_q == FINISH);
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with an ack-triggered scoreboard.
// Stimulus pushes the expected {count, timeout, run length} record for each run.
// A negedge monitor pops and compares a record on every ack rise.
module tb_run_sequencer;

  localparam int CNT_W = 16;
  localparam int TMO   = 16;

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam int WD_ON = 1;
`else
  localparam int WD_ON = 0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic             done;
  logic             run_en;
  logic             pc_clear;
  logic             ack;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  typedef struct {
    int cnt;
    int to;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_len  = 0;
  logic ack_prev = 1'b0;

  run_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .run_en     (run_en),
    .pc_clear   (pc_clear),
    .ack        (ack),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input int to, input int len);
    exp_t e;
    e.cnt = cnt;
    e.to  = to;
    e.len = len;
    sb_q.push_back(e);
  endtask

  // Hold start high for nstart edges, then drop it.
  // Pulse done so that it is sampled at the close of RUN cycle k.
  task automatic run_k(input int nstart, input int k);
    start = 1'b1;
    repeat (nstart) tick();
    start = 1'b0;
    tick();                 // now in RUN cycle 1
    repeat (k - 1) tick();  // now in RUN cycle k
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Monitor: count RUN cycles since ARMED, and check one scoreboard record per ack rise.
  always @(negedge clk) begin
    if (pc_clear) run_len = 0;
    else if (run_en) run_len++;
    if (ack && !ack_prev) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_cycle_count", int'(cycle_count), e.cnt);
        chk("sb_timeout", int'(timeout), e.to);
        chk("sb_run_len", run_len, e.len);
      end
    end
    ack_prev = ack;
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    #12;
    chk("rst_run_en", int'(run_en), 0);
    chk("rst_pc_clear", int'(pc_clear), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_count", int'(cycle_count), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // Basic run: start high for 3 cycles, done in RUN cycle 7.
    push(7, 0, 7);
    run_k(3, 7);
    chk("t1_ack", int'(ack), 1);
    chk("t1_run_en_low", int'(run_en), 0);
    tick();
    chk("t1_count_frozen", int'(cycle_count), 7);

    // Back-to-back run: a 1-cycle start pulse, done in RUN cycle 3.
    push(3, 0, 3);
    start = 1'b1;
    tick();
    chk("b2b_ack_drop", int'(ack), 0);
    chk("b2b_pc_clear", int'(pc_clear), 1);
    chk("b2b_count_clr", int'(cycle_count), 0);
    start = 1'b0;
    tick();
    chk("b2b_pc_clear_1cyc", int'(pc_clear), 0);
    chk("b2b_run_en", int'(run_en), 1);
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("b2b_ack", int'(ack), 1);

    // Done on the same cycle the watchdog would fire: done wins, so timeout stays 0.
    push(TMO, 0, TMO);
    run_k(1, TMO);
    chk("tie_timeout", int'(timeout), 0);

    // Async reset mid-RUN, applied between clock edges.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_run_en", int'(run_en), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_run_en", int'(run_en), 0);
    chk("arst_pc_clear", int'(pc_clear), 0);
    chk("arst_ack", int'(ack), 0);
    chk("arst_count", int'(cycle_count), 0);
    tick();
    #2 reset = 1'b1;
    tick();
    // Done in IDLE and ARMED is ignored. Start toggling in RUN is ignored.
    done = 1'b1;
    tick();
    tick();
    chk("idle_done_pc_clear", int'(pc_clear), 0);
    chk("idle_done_ack", int'(ack), 0);
    push(6, 0, 6);
    start = 1'b1;
    tick();
    tick();
    chk("armed_done_pc_clear", int'(pc_clear), 1);
    chk("armed_done_ack", int'(ack), 0);
    chk("armed_done_run_en", int'(run_en), 0);
    start = 1'b0;
    done  = 1'b0;
    tick();                 // RUN cycle 1
    tick();                 // RUN cycle 2
    start = 1'b1;
    tick();
    tick();                 // RUN cycle 4
    chk("run_start_ign_run_en", int'(run_en), 1);
    chk("run_start_ign_pc_clear", int'(pc_clear), 0);
    start = 1'b0;
    tick();
    tick();                 // RUN cycle 6
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ign_ack", int'(ack), 1);

    // Watchdog, or counter saturation when the watchdog is not built.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();                 // RUN cycle 1
    if (WD_ON != 0) begin
      bit seen;
      seen = 1'b0;
      push(TMO, 1, TMO);
      for (int i = 0; i < 40 && !seen; i++) begin
        tick();
        if (ack) seen = 1'b1;
      end
      chk("wd_ack_seen", int'(seen), 1);
      repeat (3) tick();
      chk("wd_timeout_frozen", int'(timeout), 1);
      chk("wd_count_frozen", int'(cycle_count), TMO);
    end else begin
      repeat (65535) tick();
      chk("sat_count_max", int'(cycle_count), 65535);
      repeat (3) tick();    // RUN cycle 65539
      chk("sat_count_hold", int'(cycle_count), 65535);
      chk("sat_no_ack", int'(ack), 0);
      chk("sat_timeout", int'(timeout), 0);
      chk("sat_run_en", int'(run_en), 1);
      push(65535, 0, 65539);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("sat_done_ack", int'(ack), 1);
    end

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
